// File: rtl/spi_byte_parser.sv
// SPI byte parser: turns CS-delimited byte streams from the SPI slave receiver
// into LED colour RAM writes (24-bit GRB pixels) and a timing configuration byte.
// Optional build macro FRAME_PIXEL_CNT_EN adds pixel_cnt_out, the number of
// pixels written in the last completed data frame (saturating at 2^ADDR_WIDTH).

module spi_byte_parser #(
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] CMD_CONF   = 8'h2A,
  parameter logic [7:0] CMD_DATA   = 8'hCC,
  parameter logic [7:0] CONF_RST   = 8'h10
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  spi_rdy_in,
  input  logic [7:0]            spi_data_in,
  input  logic                  spi_cs_n_in,
  output logic                  ram_wr_en_out,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_out,
  output logic [23:0]           ram_wr_data_out,
  output logic [7:0]            conf_t0h_out,
  output logic                  frame_done_out
`ifdef FRAME_PIXEL_CNT_EN
  ,
  output logic [ADDR_WIDTH:0]   pixel_cnt_out
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    CONF,
    DATA,
    DISCARD
  } state_t;

  state_t                state;
  logic                  cs_meta;
  logic                  cs_sync;
  logic                  cs_prev;
  logic                  cs_fall;
  logic                  cs_rise;
  logic [1:0]            byte_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            slot0;
  logic [7:0]            slot1;
  logic                  frame_any;
  logic                  done_pending;
  logic                  frame_start;
  logic                  pixel_done;
  logic                  frame_end;
  logic                  frame_end_late;

  // Chip select synchroniser plus edge register; idles high so reset looks deselected
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
      cs_prev <= 1'b1;
    end else begin
      cs_meta <= spi_cs_n_in;
      cs_sync <= cs_meta;
      cs_prev <= cs_sync;
    end
  end

  assign cs_fall = cs_prev & ~cs_sync;
  assign cs_rise = ~cs_prev & cs_sync;

  // Decode this cycle's events; a completing pixel that meets cs_rise delays frame_done by one cycle
  always_comb begin
    frame_start    = 1'b0;
    pixel_done     = 1'b0;
    frame_end      = 1'b0;
    frame_end_late = 1'b0;
    if (!cs_fall) begin
      frame_start = (state == CMD) && spi_rdy_in && (spi_data_in == CMD_DATA);
      pixel_done  = (state == DATA) && spi_rdy_in && (byte_cnt == 2'd2);
      if (cs_rise && (state == DATA)) begin
        frame_end_late = pixel_done;
        frame_end      = !pixel_done && frame_any;
      end
    end
  end

  // Transaction FSM with registered RAM, configuration and frame-done outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      byte_cnt        <= 2'd0;
      addr            <= '0;
      slot0           <= 8'h00;
      slot1           <= 8'h00;
      frame_any       <= 1'b0;
      done_pending    <= 1'b0;
      ram_wr_en_out   <= 1'b0;
      ram_wr_addr_out <= '0;
      ram_wr_data_out <= 24'h000000;
      conf_t0h_out    <= CONF_RST;
      frame_done_out  <= 1'b0;
    end else begin
      ram_wr_en_out  <= 1'b0;
      frame_done_out <= frame_end | done_pending;
      done_pending   <= frame_end_late;
      if (cs_fall) begin
        state    <= CMD;
        byte_cnt <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
          end
          CMD: begin
            if (spi_rdy_in) begin
              if (spi_data_in == CMD_CONF) begin
                state <= CONF;
              end else if (frame_start) begin
                state     <= DATA;
                byte_cnt  <= 2'd0;
                addr      <= '0;
                frame_any <= 1'b0;
              end else begin
                state <= DISCARD;
              end
            end
          end
          CONF: begin
            if (spi_rdy_in) begin
              conf_t0h_out <= spi_data_in;
              state        <= DISCARD;
            end
          end
          DATA: begin
            if (spi_rdy_in) begin
              case (byte_cnt)
                2'd0: begin
                  slot0    <= spi_data_in;
                  byte_cnt <= 2'd1;
                end
                2'd1: begin
                  slot1    <= spi_data_in;
                  byte_cnt <= 2'd2;
                end
                default: begin
                  ram_wr_en_out   <= 1'b1;
                  ram_wr_addr_out <= addr;
                  ram_wr_data_out <= {slot0, slot1, spi_data_in};
                  addr            <= addr + ADDR_WIDTH'(1);
                  byte_cnt        <= 2'd0;
                  frame_any       <= 1'b1;
                end
              endcase
            end
          end
          DISCARD: begin
          end
          default: begin
            state <= IDLE;
          end
        endcase
        if (cs_rise && (state != IDLE)) begin
          state <= IDLE;
        end
      end
    end
  end

`ifdef FRAME_PIXEL_CNT_EN
  localparam logic [ADDR_WIDTH:0] PIX_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0] frame_pix;

  // Count pixels of the current frame and publish the total alongside frame_done_out
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_pix     <= '0;
      pixel_cnt_out <= '0;
    end else begin
      if (frame_start) begin
        frame_pix <= '0;
      end else if (pixel_done && (frame_pix != PIX_MAX)) begin
        frame_pix <= frame_pix + (ADDR_WIDTH + 1)'(1);
      end
      if (frame_end || done_pending) begin
        pixel_cnt_out <= frame_pix;
      end
    end
  end
`endif

endmodule

// File: doc/spi_byte_parser.md
Name: spi_byte_parser

Overview:
- Sits directly downstream of the SPI slave receiver and consumes its byte-ready pulse and 8-bit byte.
- Parses each CS-delimited SPI transaction as one command byte followed by payload bytes.
- Packs pixel payload into 24-bit GRB words and writes them into the LED colour RAM.
- Latches the timing configuration byte and pulses a frame-done strobe for the LED output stage.

Parameters:
- ADDR_WIDTH, 8, colour RAM address width; the pixel address wraps modulo 2^ADDR_WIDTH.
- CMD_CONF, 8'h2A, command code for a timing configuration write.
- CMD_DATA, 8'hCC, command code for a pixel data write.
- CONF_RST, 8'h10, reset value of the timing configuration register.

Ports:
- clk_in  input  1  system clock; the single clock domain of this block.
- rst_n_in  input  1  asynchronous active-low reset.
- spi_rdy_in  input  1  one-clk_in-cycle pulse; a new byte is valid on spi_data_in.
- spi_data_in  input  8  received byte, valid in the cycle spi_rdy_in is high.
- spi_cs_n_in  input  1  raw SPI chip select, asynchronous to clk_in; synchronised internally.
- ram_wr_en_out  output  1  colour RAM write strobe, one cycle per pixel.
- ram_wr_addr_out  output  ADDR_WIDTH  colour RAM write address.
- ram_wr_data_out  output  24  pixel word {byte0, byte1, byte2} in GRB order.
- conf_t0h_out  output  8  latched timing configuration byte.
- frame_done_out  output  1  one-cycle pulse at the end of a data frame.

Behaviour:
- Reset (async, rst_n_in low):
  - All outputs 0 except conf_t0h_out = CONF_RST.
  - FSM goes to IDLE; byte counter and address counter cleared; CS synchroniser preset to 1.
- CS handling:
  - 2-flop synchroniser, then an edge register.
  - cs_fall is asserted for one cycle on sync 1->0; cs_rise is asserted for one cycle on sync 0->1.
- FSM states: IDLE, CMD, CONF, DATA, DISCARD.
  - IDLE: on cs_fall -> CMD. spi_rdy_in is ignored in IDLE.
  - CMD: on spi_rdy_in, if the byte equals CMD_CONF -> CONF.
  - CMD: on spi_rdy_in, if the byte equals CMD_DATA -> DATA; clear the address and byte counters.
  - CMD: on spi_rdy_in, any other byte -> DISCARD.
  - CONF: the first spi_rdy_in loads conf_t0h_out with the data byte -> DISCARD. Later bytes are ignored.
  - DATA: each spi_rdy_in stores the byte into slot byte_cnt (0..2) and increments byte_cnt.
    - On the third byte, byte_cnt wraps to 0.
    - In the next cycle: ram_wr_en_out=1, ram_wr_data_out = assembled word, ram_wr_addr_out = current address.
    - The address then post-increments, wrapping from 2^ADDR_WIDTH-1 to 0.
  - DISCARD: all bytes are ignored until cs_rise.
  - From any non-IDLE state, cs_rise -> IDLE.
- Simultaneous spi_rdy_in and cs_rise: the byte is processed first in the current state (including a completing pixel write), then the FSM goes to IDLE.
- frame_done_out:
  - Pulses for one cycle, the cycle after cs_rise, only when leaving DATA with at least one pixel written in that frame.
  - When a pixel write and frame end coincide, frame_done_out follows ram_wr_en_out by at least one cycle.
- A partial pixel (1 or 2 bytes) at frame end is discarded; no write occurs.
- ram_wr_en_out is never high for two consecutive cycles. ram_wr_addr_out and ram_wr_data_out hold their values between writes.
- cs_fall while not in IDLE (glitch or missed rise): re-enter CMD and clear byte_cnt.
- Reset asserted mid-frame: immediate return to reset values. After release, bytes are ignored until a fresh cs_fall.

Optional Feature:
- Macro: FRAME_PIXEL_CNT_EN.
- When defined:
  - Adds output pixel_cnt_out, width ADDR_WIDTH+1.
  - Updated in the same cycle as frame_done_out with the number of pixels written in that frame, saturating at 2^ADDR_WIDTH.
  - Reset value 0; holds its value otherwise.
- When not defined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Config write: cs low, bytes 2A,55, cs high -> conf_t0h_out=8'h55; no RAM write; no frame_done_out.
- Data frame: cs low, bytes CC,11,22,33,44,55,66, cs high:
  - writes addr0=24'h112233 and addr1=24'h445566, each strobe one cycle wide.
  - frame_done_out pulses once after cs_rise.
  - with FRAME_PIXEL_CNT_EN, pixel_cnt_out=2.
- Partial pixel: CC,AA,BB,CC,DD, cs high -> exactly one write (addr0=24'hAABBCC); DD is dropped; the next frame starts at addr0.
- Wrap: ADDR_WIDTH=2, frame of CC plus 5 pixels -> addresses 0,1,2,3,0; with the macro, pixel_cnt_out=4 (saturated).
- Unknown and edge commands:
  - byte 7F then 11,22,33 -> no write, conf_t0h_out unchanged, no frame_done_out.
  - frame CC with no payload -> no frame_done_out.
- Reset mid-frame: rst_n_in low after CC,11 -> outputs return to reset values (conf_t0h_out=8'h10). After release, bytes without a new cs_fall produce no write.
